// File: rtl/dec2bin_pkg.sv
// Shared types and constants for the decimal-to-binary accumulator.
package dec2bin_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DONE
  } state_t;

  localparam logic [3:0] BCD_MAX    = 4'd9;
  localparam logic [3:0] MINUS_CODE = 4'hA;

  function automatic logic is_bcd(input logic [3:0] d);
    return d <= BCD_MAX;
  endfunction

endpackage

// File: rtl/mul10_add.sv
// Combinational acc*10 + d using shift-add, widened by 4 bits so it cannot wrap.
module mul10_add #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] acc,
  input  logic [3:0]       d,
  output logic [WIDTH+3:0] y
);

  logic [WIDTH+3:0] ext;

  assign ext = {4'b0000, acc};
  assign y   = (ext << 3) + (ext << 1) + {{WIDTH{1'b0}}, d};

endmodule

// File: rtl/dec2bin_accum.sv
// Sequential BCD-to-binary converter: acc = acc*10 + digit per accepted digit.
// Define DEC2BIN_SIGN_EN to accept a leading minus code and produce a signed result.
module dec2bin_accum
  import dec2bin_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int MAX_DIGITS = 5
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clear,
  input  logic                          digit_valid,
  input  logic [3:0]                    digit_in,
  input  logic                          digit_last,
  output logic                          digit_ready,
  output logic [WIDTH-1:0]              result,
  output logic                          result_valid,
  input  logic                          result_ack,
  output logic                          overflow,
  output logic                          bad_digit,
  output logic [$clog2(MAX_DIGITS+1)-1:0] digit_count
);

  localparam int CW = $clog2(MAX_DIGITS+1);
  localparam int XW = WIDTH + 4;

  state_t           state;
  logic [WIDTH-1:0] acc;
  logic             ovf;
  logic             neg;

  logic [XW-1:0]    prod;
  logic [XW-1:0]    limit;
  logic             take;
  logic             numeric;

  logic [WIDTH-1:0] acc_nxt;
  logic             ovf_nxt;
  logic             neg_nxt;
  logic [CW-1:0]    cnt_nxt;
  logic             bad_nxt;
  logic [WIDTH-1:0] res_nxt;

  mul10_add #(.WIDTH(WIDTH)) u_mul10 (
    .acc (acc),
    .d   (digit_in),
    .y   (prod)
  );

  assign digit_ready = ~rst & (state != DONE);
  assign take        = digit_valid & digit_ready;
  assign numeric     = is_bcd(digit_in);

`ifdef DEC2BIN_SIGN_EN
  assign limit = neg ? {4'b0000, 1'b1, {(WIDTH-1){1'b0}}}
                     : {5'b00000, {(WIDTH-1){1'b1}}};
`else
  assign limit = {4'b0000, {WIDTH{1'b1}}};
`endif

  always_comb begin
    acc_nxt = acc;
    ovf_nxt = ovf;
    neg_nxt = neg;
    cnt_nxt = digit_count;
    bad_nxt = 1'b0;
    if (take) begin
      if (numeric) begin
        if (digit_count == CW'(MAX_DIGITS)) begin
          ovf_nxt = 1'b1;
        end else begin
          cnt_nxt = digit_count + CW'(1);
          if (prod > limit) begin
            ovf_nxt = 1'b1;
            acc_nxt = limit[WIDTH-1:0];
          end else begin
            acc_nxt = prod[WIDTH-1:0];
          end
        end
`ifdef DEC2BIN_SIGN_EN
      end else if (digit_in == MINUS_CODE && state == IDLE) begin
        neg_nxt = 1'b1;
`endif
      end else begin
        bad_nxt = 1'b1;
      end
    end
    // Negation uses the updated magnitude so the last digit is included.
    res_nxt = neg_nxt ? (~acc_nxt) + WIDTH'(1) : acc_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      acc          <= '0;
      ovf          <= 1'b0;
      neg          <= 1'b0;
      digit_count  <= '0;
      result       <= '0;
      result_valid <= 1'b0;
      overflow     <= 1'b0;
      bad_digit    <= 1'b0;
    end else if (clear) begin
      state        <= IDLE;
      acc          <= '0;
      ovf          <= 1'b0;
      neg          <= 1'b0;
      digit_count  <= '0;
      result       <= '0;
      result_valid <= 1'b0;
      overflow     <= 1'b0;
      bad_digit    <= 1'b0;
    end else begin
      bad_digit <= bad_nxt;
      case (state)
        IDLE, ACCUM: begin
          acc         <= acc_nxt;
          ovf         <= ovf_nxt;
          neg         <= neg_nxt;
          digit_count <= cnt_nxt;
          if (take && digit_last) begin
            state        <= DONE;
            result       <= res_nxt;
            overflow     <= ovf_nxt;
            result_valid <= 1'b1;
          end else if (take && numeric) begin
            state <= ACCUM;
          end
        end
        DONE: begin
          if (result_ack) begin
            state        <= IDLE;
            acc          <= '0;
            ovf          <= 1'b0;
            neg          <= 1'b0;
            digit_count  <= '0;
            result_valid <= 1'b0;
            overflow     <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/dec2bin_accum.md
Name: dec2bin_accum

Overview:
- Sequential decimal-to-binary converter for the calculator datapath; the inverse direction of the binary-to-decimal digit path.
- Accepts BCD digits one at a time over a valid/ready handshake, most significant digit first, and computes acc = acc*10 + digit each accepted digit.
- Presents the final WIDTH-bit binary operand with overflow and bad-digit status to the ALU/register-file side.

Parameters:
- WIDTH, 16, bit width of binary result and accumulator.
- MAX_DIGITS, 5, maximum decimal digits per number; digits beyond this set overflow.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- clear  input  1  synchronous abort; highest priority after rst.
- digit_valid  input  1  digit_in/digit_last valid.
- digit_in  input  4  BCD digit 0-9; other codes invalid (see Optional Feature for 4'hA).
- digit_last  input  1  marks final digit of the number.
- digit_ready  output  1  block can accept a digit.
- result  output  WIDTH  binary value, held while result_valid.
- result_valid  output  1  result available; held until result_ack.
- result_ack  input  1  consumer takes result.
- overflow  output  1  result exceeded range or digit limit; valid with result_valid.
- bad_digit  output  1  one-cycle pulse: invalid code accepted.
- digit_count  output  $clog2(MAX_DIGITS+1)  numeric digits accumulated so far.

Behaviour:
- Reset (async, rst=1): state IDLE, acc=0, result=0, result_valid=0, overflow=0, bad_digit=0, digit_count=0, digit_ready=0 while rst is high, 1 in the first cycle after release.
- States: IDLE (no digits yet), ACCUM (at least one digit taken), DONE (result held).
- Handshake: a digit transfers on a clk edge where digit_valid and digit_ready are both 1. digit_ready=1 in IDLE and ACCUM, 0 in DONE.
- Valid digit (0-9) accepted: next_acc = acc*10 + digit_in. Compute at WIDTH+4 bits. If next_acc > 2^WIDTH-1, set sticky ovf and saturate acc to all ones. digit_count increments and saturates at MAX_DIGITS. A numeric digit accepted when digit_count==MAX_DIGITS sets ovf and leaves acc unchanged. IDLE->ACCUM.
- Invalid code accepted: consumed; acc and digit_count unchanged; bad_digit=1 for the next cycle only; state unchanged.
- digit_last with the accepted digit: the digit is applied first. Next edge: state DONE, result=final acc, overflow=ovf, result_valid=1. Latency is one cycle from the last-digit handshake to result_valid.
- digit_last on an invalid code: finishes with the current acc. digit_last in IDLE with an invalid code gives result=0.
- DONE: result, overflow and result_valid are stable. result_ack=1 -> next edge IDLE, acc=0, ovf=0, digit_count=0, result_valid=0. digit_ready returns to 1 the cycle after ack.
- clear=1 at any state: next edge equals the post-reset state. clear wins over a simultaneous digit handshake or result_ack. The bad_digit pulse is suppressed.
- digit_valid while digit_ready=0: ignored; the producer must hold the digit.

Optional Feature:
- Macro DEC2BIN_SIGN_EN.
- Defined:
  - digit_in=4'hA (minus) is accepted only in IDLE. It sets the neg flag, does not count as a digit, and stays in IDLE. Minus in ACCUM is treated as bad_digit.
  - Magnitude limit becomes 2^(WIDTH-1) if neg, else 2^(WIDTH-1)-1. On violation, ovf is set and the result saturates to 0x8000 / 0x7FFF for WIDTH=16.
  - result = neg ? two's complement of acc : acc.
  - neg clears on ack, clear and reset.
- Undefined: 4'hA is an ordinary invalid code, and the result is unsigned.

Decomposition:
- Package dec2bin_pkg:
  - state enum (IDLE, ACCUM, DONE)
  - BCD_MAX=4'd9
  - MINUS_CODE=4'hA
  - function for digit validity.
- One natural sub-module, mul10_add: combinational acc*10+d via (acc<<3)+(acc<<1)+d, WIDTH+4-bit output. It is used by the accumulate step and the overflow compare.

Test Plan (WIDTH=16, MAX_DIGITS=5):
- Digits 1,2,3 (last on 3) -> result_valid one cycle after the 3 handshake; result=16'd123, overflow=0; result_ack -> IDLE, digit_ready=1 the cycle after.
- Digits 6,5,5,3,5 -> result=16'hFFFF, overflow=0. Digits 6,5,5,3,6 -> result=16'hFFFF, overflow=1.
- Digits 4,4'hC,2 (last) -> bad_digit pulses once; result=16'd42, overflow=0. Then 1,2,3,4,5,6 (last) -> overflow=1, result=16'd12345, digit_count=5.
- Digits 7,8, then clear asserted together with digit 9 valid -> 9 not taken; acc=0, state IDLE. Then 5 (last) -> result=16'd5. rst asserted mid-ACCUM -> all outputs at reset values immediately.
- DONE hold: digit_valid=1 with digit_ready=0 for 10 cycles -> result unchanged, no digit consumed; ack with digit_valid still high -> digit accepted only from the cycle after ack.
- DEC2BIN_SIGN_EN:
  - A,3,2,7,6,8 -> 16'h8000, overflow=0.
  - A,3,2,7,6,9 -> 16'h8000, overflow=1.
  - A,1,2 -> 16'hFFF4.
  - 1,A (last) -> bad_digit pulse, result=16'd1.
